// File: rtl/pulse_stretch_driver_if.sv
// Event/level interface of the pulse stretcher.
// master: the side that raises events and watches the output level.
// slave : the stretcher itself.
interface pulse_stretch_driver_if #(
    parameter int PEND_W = 2
);
    logic              PulseIn;
    logic              ClearOvf;
    logic              SignOut;
    logic              Busy;
    logic [PEND_W-1:0] Pending;
    logic              Overflow;

    modport master (
        output PulseIn,
        output ClearOvf,
        input  SignOut,
        input  Busy,
        input  Pending,
        input  Overflow
    );

    modport slave (
        input  PulseIn,
        input  ClearOvf,
        output SignOut,
        output Busy,
        output Pending,
        output Overflow
    );
endinterface

// File: rtl/pulse_stretch_driver.sv
// Pulse stretcher: every single-cycle event on PulseIn becomes one high burst of
// HIGH_CYCLES cycles on SignOut. Bursts are followed by at least GAP_CYCLES low cycles.
// Events that arrive during a burst or gap wait in a saturating pending counter.
// If the queue is full, the event is dropped and the sticky Overflow flag is set.
module pulse_stretch_driver #(
    parameter int HIGH_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int PEND_W      = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    pulse_stretch_driver_if.slave        bus
);
    localparam int MAX_CYC = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // The counter holds the number of cycles left in the current state after this one.
    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [PEND_W-1:0] pend_q,  pend_d;
    logic              ovf_q,   ovf_d;
    logic              sign_q,  sign_d;
    logic              busy_q,  busy_d;

    logic start;   // enter HIGH on the next cycle
    logic dec;     // one queued event is taken this cycle
    logic enq;     // the event on PulseIn goes to the queue this cycle
    logic drop;    // the event on PulseIn is lost because the queue is full

    // Next-state logic: state sequencing, queue accounting and overflow flag.
    always_comb begin
        // NOTE: give every comb output a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        start   = 1'b0;
        dec     = 1'b0;
        enq     = 1'b0;
        drop    = 1'b0;

        unique case (state_q)
            IDLE: begin
                start = bus.PulseIn;
            end
            HIGH: begin
                enq = bus.PulseIn;
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    if (pend_q != '0) begin
                        // Queued work has priority. A new event in the same cycle replaces the slot it frees.
                        start = 1'b1;
                        dec   = 1'b1;
                        enq   = bus.PulseIn;
                    end else if (bus.PulseIn) begin
                        // The queue is empty, so the event starts the next burst directly.
                        start = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    enq   = bus.PulseIn;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (start) begin
            state_d = HIGH;
            cnt_d   = HIGH_LOAD;
        end

        // Saturating queue arithmetic. A simultaneous take and add cancel out.
        if (enq && dec) begin
            pend_d = pend_q;
        end else if (dec) begin
            pend_d = pend_q - PEND_ONE;
        end else if (enq) begin
            if (pend_q != PEND_MAX) begin
                pend_d = pend_q + PEND_ONE;
            end else begin
                drop = 1'b1;
            end
        end

        // A drop in the same cycle as ClearOvf keeps the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.ClearOvf) begin
            ovf_d = 1'b0;
        end

        sign_d = (state_d == HIGH);
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs. Synchronous reset overrides every other input.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            sign_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            sign_q  <= sign_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.SignOut  = sign_q;
    assign bus.Busy     = busy_q;
    assign bus.Pending  = pend_q;
    assign bus.Overflow = ovf_q;
endmodule

// File: tb/tb_pulse_stretch_driver.sv
// Directed testbench for pulse_stretch_driver.
// A timing model tracks the start edge of the current burst and derives the phase from elapsed cycles.
// A few literal expectations per scenario pin the model itself.
module tb_pulse_stretch_driver;
    localparam int H    = 4;
    localparam int G    = 2;
    localparam int PW   = 2;
    localparam int PMAX = (1 << PW) - 1;
    localparam int NMAX = 64;

    logic clk = 1'b0;
    logic reset;

    pulse_stretch_driver_if #(.PEND_W(PW)) bus ();

    pulse_stretch_driver #(
        .HIGH_CYCLES(H),
        .GAP_CYCLES (G),
        .PEND_W     (PW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: whether a burst has ever started since reset, its start edge, queue and flag.
    bit m_active;
    int m_tstart;
    int m_pend;
    bit m_ovf;

    // Observed DUT outputs after edge k of the current scenario.
    int sign_h [NMAX];
    int busy_h [NMAX];
    int pend_h [NMAX];
    int ovf_h  [NMAX];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Advance the model by one clock edge n, using the inputs sampled at that edge.
    task automatic model_step(input int n, input bit r, input bit p, input bit c);
        int  eprev;
        bit  busy_prev, last_gap, start, dec, enq, drop;
        if (r) begin
            m_active = 1'b0;
            m_pend   = 0;
            m_ovf    = 1'b0;
            return;
        end
        eprev     = n - 1 - m_tstart;
        busy_prev = m_active && (eprev < H + G);
        last_gap  = m_active && (eprev == H + G - 1);
        start = 0; dec = 0; enq = 0; drop = 0;
        if (!busy_prev) begin
            start = p;
        end else if (last_gap) begin
            if (m_pend > 0) begin
                start = 1; dec = 1; enq = p;
            end else begin
                start = p;
            end
        end else begin
            enq = p;
        end
        if (dec && !enq)      m_pend = m_pend - 1;
        else if (enq && !dec) begin
            if (m_pend < PMAX) m_pend = m_pend + 1;
            else               drop = 1;
        end
        if (drop)   m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        if (start) begin
            m_active = 1'b1;
            m_tstart = n;
        end
    endtask

    // Run one scenario. Bit k of each mask is the input value sampled at edge k.
    task automatic run(input string tag, input logic [63:0] pm, input logic [63:0] cm,
                       input logic [63:0] rm, input int ncyc);
        int e;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            reset        = rm[k];
            bus.PulseIn  = pm[k];
            bus.ClearOvf = cm[k];
            @(posedge clk);
            model_step(k, rm[k], pm[k], cm[k]);
            #1;
            e = k - m_tstart;
            check($sformatf("%s SignOut@%0d", tag, k + 1), 32'(bus.SignOut),
                  32'(m_active && (e < H)));
            check($sformatf("%s Busy@%0d", tag, k + 1), 32'(bus.Busy),
                  32'(m_active && (e < H + G)));
            check($sformatf("%s Pending@%0d", tag, k + 1), 32'(bus.Pending), 32'(m_pend));
            check($sformatf("%s Overflow@%0d", tag, k + 1), 32'(bus.Overflow), 32'(m_ovf));
            sign_h[k] = int'(bus.SignOut);
            busy_h[k] = int'(bus.Busy);
            pend_h[k] = int'(bus.Pending);
            ovf_h[k]  = int'(bus.Overflow);
        end
    endtask

    // Value seen at cycle N is the register value after edge N-1.
    function automatic int sig(input int n); return sign_h[n-1]; endfunction
    function automatic int bsy(input int n); return busy_h[n-1]; endfunction
    function automatic int pnd(input int n); return pend_h[n-1]; endfunction
    function automatic int ovf(input int n); return ovf_h[n-1];  endfunction

    initial begin
        int bursts;
        int highs;
        reset        = 1'b1;
        bus.PulseIn  = 1'b0;
        bus.ClearOvf = 1'b0;
        m_active     = 1'b0;
        m_tstart     = 0;
        m_pend       = 0;
        m_ovf        = 1'b0;

        // 1: single pulse
        run("T1", rng(10, 10), '0, rng(0, 1), 22);
        check("T1 reset SignOut", 32'(sig(3)), 0);
        for (int n = 11; n <= 14; n++) check($sformatf("T1 lit SignOut@%0d", n), 32'(sig(n)), 1);
        check("T1 lit SignOut@15", 32'(sig(15)), 0);
        check("T1 lit Busy@16", 32'(bsy(16)), 1);
        check("T1 lit Busy@17", 32'(bsy(17)), 0);

        // 2: three back-to-back pulses
        run("T2", rng(10, 12), '0, rng(0, 1), 34);
        check("T2 lit Pending@13", 32'(pnd(13)), 2);
        check("T2 lit SignOut@16", 32'(sig(16)), 0);
        check("T2 lit SignOut@17", 32'(sig(17)), 1);
        check("T2 lit SignOut@26", 32'(sig(26)), 1);
        check("T2 lit SignOut@27", 32'(sig(27)), 0);
        check("T2 lit Busy@28", 32'(bsy(28)), 1);
        check("T2 lit Busy@29", 32'(bsy(29)), 0);

        // 3: queue saturation and drop
        run("T3", rng(10, 14), '0, rng(0, 1), 40);
        check("T3 lit Pending@14", 32'(pnd(14)), 3);
        check("T3 lit Overflow@14", 32'(ovf(14)), 0);
        check("T3 lit Overflow@15", 32'(ovf(15)), 1);
        bursts = 0;
        for (int k = 1; k < 40; k++) if (sign_h[k] == 1 && sign_h[k-1] == 0) bursts++;
        check("T3 burst count", 32'(bursts), 4);

        // 4: pulse on the last gap cycle starts the next burst directly
        run("T4", rng(10, 10) | rng(16, 16), '0, rng(0, 1), 28);
        check("T4 lit SignOut@16", 32'(sig(16)), 0);
        check("T4 lit SignOut@17", 32'(sig(17)), 1);
        check("T4 lit SignOut@20", 32'(sig(20)), 1);
        check("T4 lit Busy@17", 32'(bsy(17)), 1);
        check("T4 lit Pending@17", 32'(pnd(17)), 0);

        // 5: reset mid-HIGH with queued work and overflow set
        run("T5", rng(5, 9), '0, rng(0, 1) | rng(12, 12), 40);
        check("T5 lit Pending@12", 32'(pnd(12)), 2);
        check("T5 lit Overflow@12", 32'(ovf(12)), 1);
        check("T5 lit SignOut@12", 32'(sig(12)), 1);
        check("T5 lit SignOut@13", 32'(sig(13)), 0);
        check("T5 lit Busy@13", 32'(bsy(13)), 0);
        check("T5 lit Pending@13", 32'(pnd(13)), 0);
        check("T5 lit Overflow@13", 32'(ovf(13)), 0);
        highs = 0;
        for (int k = 12; k < 40; k++) highs += sign_h[k];
        check("T5 no bursts after reset", 32'(highs), 0);

        // 6: ClearOvf together with a drop, then ClearOvf alone
        run("T6", rng(10, 15), rng(15, 15) | rng(18, 18), rng(0, 1), 24);
        check("T6 lit Overflow@15", 32'(ovf(15)), 1);
        check("T6 lit Overflow@16", 32'(ovf(16)), 1);
        check("T6 lit Overflow@18", 32'(ovf(18)), 1);
        check("T6 lit Overflow@19", 32'(ovf(19)), 0);

        // 7: same-cycle add and take with a full queue
        run("T7", rng(10, 13) | rng(16, 16), '0, rng(0, 1), 24);
        check("T7 lit Pending@14", 32'(pnd(14)), 3);
        check("T7 lit Pending@17", 32'(pnd(17)), 3);
        check("T7 lit Overflow@17", 32'(ovf(17)), 0);
        check("T7 lit SignOut@17", 32'(sig(17)), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
